// File: rtl/register_file_sb.sv
// register_file_sb
//   16 x 16-bit register file (R0 hard-wired to zero) with a scoreboard of
//   pending writes. An issued instruction marks its destination busy, and a
//   writeback clears that mark. Reads and busy lookups are combinational.
//   With BYPASS_EN=1, a writeback in the current cycle is forwarded to the
//   read data, and the matching busy flag is masked in the same cycle.
//
// Ports
//   clk        : clock; all state changes on its rising edge
//   rst        : synchronous active-high reset
//   SrcReg1/2  : read port register IDs
//   DstReg     : writeback register ID
//   WriteReg   : writeback enable
//   DstData    : writeback data
//   IssueReg   : destination ID of the instruction issuing this cycle
//   IssueValid : issue strobe; marks IssueReg pending
//   SrcData1/2 : read data
//   Busy1/2    : source register has a pending write
//   PendingCnt : number of pending registers (registered)
module register_file_sb #(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  SrcReg1,
  input  logic [3:0]  SrcReg2,
  input  logic [3:0]  DstReg,
  input  logic        WriteReg,
  input  logic [15:0] DstData,
  input  logic [3:0]  IssueReg,
  input  logic        IssueValid,
  output logic [15:0] SrcData1,
  output logic [15:0] SrcData2,
  output logic        Busy1,
  output logic        Busy2,
  output logic [4:0]  PendingCnt
);

  logic [15:0] r_regs [16];
  logic [15:0] r_busy;
  logic [4:0]  r_pend;

  logic [15:0] w_wl;
  logic [15:0] w_set;
  logic [15:0] w_busy_nxt;
  logic [4:0]  w_cnt;
  logic        w_hit1;
  logic        w_hit2;

  // One-hot write wordline; also serves as the busy-clear mask.
  assign w_wl  = WriteReg ? (16'd1 << DstReg) : '0;
  assign w_set = (IssueValid && (IssueReg != 4'd0)) ? (16'd1 << IssueReg) : '0;

  // Clear first, then set, so a same-cycle issue to the writeback target
  // keeps the register busy for the newer producer. Bit 0 is forced low.
  assign w_busy_nxt = ((r_busy & ~w_wl) | w_set) & 16'hFFFE;

  always_comb begin
    w_cnt = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      w_cnt = w_cnt + 5'(w_busy_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 16; i++) begin
        r_regs[i] <= '0;
      end
      r_busy <= '0;
      r_pend <= '0;
    end else begin
      for (int unsigned i = 1; i < 16; i++) begin
        if (w_wl[i]) begin
          r_regs[i] <= DstData;
        end
      end
      r_busy <= w_busy_nxt;
      r_pend <= w_cnt;
    end
  end

  assign w_hit1 = BYPASS_EN && WriteReg && (DstReg == SrcReg1);
  assign w_hit2 = BYPASS_EN && WriteReg && (DstReg == SrcReg2);

  always_comb begin
    SrcData1 = '0;
    SrcData2 = '0;
    if (SrcReg1 != 4'd0) begin
      SrcData1 = w_hit1 ? DstData : r_regs[SrcReg1];
    end
    if (SrcReg2 != 4'd0) begin
      SrcData2 = w_hit2 ? DstData : r_regs[SrcReg2];
    end
  end

  assign Busy1      = r_busy[SrcReg1] & ~w_hit1;
  assign Busy2      = r_busy[SrcReg2] & ~w_hit2;
  assign PendingCnt = r_pend;

endmodule

// File: tb/tb_register_file_sb.sv
module tb_register_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  s1, s2, dst, ir;
  logic        we, iv;
  logic [15:0] din;

  logic [15:0] d1_b, d2_b, d1_n, d2_n;
  logic        b1_b, b2_b, b1_n, b2_n;
  logic [4:0]  pc_b, pc_n;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  logic [15:0] m_regs [16];
  bit          m_busy [16];
  bit          m_valid = 1'b0;

  always #5 clk = ~clk;

  register_file_sb #(.BYPASS_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .SrcReg1(s1), .SrcReg2(s2), .DstReg(dst),
    .WriteReg(we), .DstData(din), .IssueReg(ir), .IssueValid(iv),
    .SrcData1(d1_b), .SrcData2(d2_b), .Busy1(b1_b), .Busy2(b2_b),
    .PendingCnt(pc_b)
  );

  register_file_sb #(.BYPASS_EN(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .SrcReg1(s1), .SrcReg2(s2), .DstReg(dst),
    .WriteReg(we), .DstData(din), .IssueReg(ir), .IssueValid(iv),
    .SrcData1(d1_n), .SrcData2(d2_n), .Busy1(b1_n), .Busy2(b2_n),
    .PendingCnt(pc_n)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_data(input logic [3:0] src, input bit byp);
    if (src == 0) return 16'h0000;
    if (byp && we && dst == src) return din;
    return m_regs[src];
  endfunction

  function automatic logic exp_busy(input logic [3:0] src, input bit byp);
    if (byp && we && dst == src) return 1'b0;
    return m_busy[src];
  endfunction

  function automatic logic [15:0] exp_cnt();
    int n = 0;
    for (int i = 0; i < 16; i++) if (m_busy[i]) n++;
    return 16'(n);
  endfunction

  // Compare both instances against the model for the current inputs.
  task automatic compare_model();
    if (!m_valid) return;
    chk("model_d1_byp",  d1_b, exp_data(s1, 1'b1));
    chk("model_d2_byp",  d2_b, exp_data(s2, 1'b1));
    chk("model_b1_byp",  16'(b1_b), 16'(exp_busy(s1, 1'b1)));
    chk("model_b2_byp",  16'(b2_b), 16'(exp_busy(s2, 1'b1)));
    chk("model_pc_byp",  16'(pc_b), exp_cnt());
    chk("model_d1_nb",   d1_n, exp_data(s1, 1'b0));
    chk("model_d2_nb",   d2_n, exp_data(s2, 1'b0));
    chk("model_b1_nb",   16'(b1_n), 16'(exp_busy(s1, 1'b0)));
    chk("model_b2_nb",   16'(b2_n), 16'(exp_busy(s2, 1'b0)));
    chk("model_pc_nb",   16'(pc_n), exp_cnt());
  endtask

  task automatic drive(input logic r, input logic [3:0] a1, input logic [3:0] a2,
                       input logic w, input logic [3:0] d, input logic [15:0] dd,
                       input logic v, input logic [3:0] i);
    rst = r; s1 = a1; s2 = a2; we = w; dst = d; din = dd; iv = v; ir = i;
    #1;
    compare_model();
  endtask

  // Advance one clock and apply the architectural rules to the model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_regs[i] = 16'h0000;
        m_busy[i] = 1'b0;
      end
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (we && dst != 0) m_regs[dst] = din;
      if (we) m_busy[dst] = 1'b0;
      if (iv && ir != 0) m_busy[ir] = 1'b1;
    end
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 16'h0, 0, 0);
    tick();
    drive(1, 0, 0, 1, 4'd6, 16'h7777, 1, 4'd6);
    tick();

    // Reset state
    drive(0, 4'd5, 4'd6, 0, 0, 16'h0, 0, 0);
    chk("rst_pc", 16'(pc_b), 16'd0);
    chk("rst_d1", d1_b, 16'h0000);
    chk("rst_d2_rst_priority", d2_b, 16'h0000);
    chk("rst_b2", 16'(b2_b), 16'd0);

    // Plain write then read; write to R0 ignored
    drive(0, 0, 0, 1, 4'd3, 16'hBEEF, 0, 0);
    tick();
    drive(0, 4'd3, 0, 0, 0, 16'h0, 0, 0);
    chk("rd_r3", d1_b, 16'hBEEF);
    drive(0, 4'd0, 0, 1, 4'd0, 16'h1234, 0, 0);
    chk("r0_same", d1_b, 16'h0000);
    tick();
    drive(0, 4'd0, 0, 0, 0, 16'h0, 0, 0);
    chk("r0_after", d1_b, 16'h0000);

    // Same-cycle forwarding vs none
    drive(0, 0, 4'd5, 1, 4'd5, 16'hA5A5, 0, 0);
    chk("byp_d2", d2_b, 16'hA5A5);
    chk("nobyp_d2", d2_n, 16'h0000);
    tick();
    drive(0, 0, 4'd5, 0, 0, 16'h0, 0, 0);
    chk("nobyp_d2_next", d2_n, 16'hA5A5);

    // Issue / writeback busy tracking
    drive(0, 0, 0, 0, 0, 16'h0, 1, 4'd7);
    tick();
    drive(0, 4'd7, 0, 0, 0, 16'h0, 0, 0);
    chk("busy7", 16'(b1_b), 16'd1);
    chk("pc_1", 16'(pc_b), 16'd1);
    drive(0, 4'd7, 0, 1, 4'd7, 16'h0707, 0, 0);
    chk("busy7_fwd_clear", 16'(b1_b), 16'd0);
    chk("busy7_nb_still", 16'(b1_n), 16'd1);
    tick();
    drive(0, 4'd7, 0, 0, 0, 16'h0, 0, 0);
    chk("pc_0", 16'(pc_b), 16'd0);

    // Issue and writeback to the same busy register: set wins
    drive(0, 0, 0, 0, 0, 16'h0, 1, 4'd4);
    tick();
    drive(0, 0, 0, 1, 4'd4, 16'h4444, 1, 4'd4);
    tick();
    drive(0, 4'd4, 0, 0, 0, 16'h0, 0, 0);
    chk("busy4_kept", 16'(b1_b), 16'd1);
    chk("pc_4_kept", 16'(pc_b), 16'd1);
    chk("r4_data", d1_b, 16'h4444);

    // Fill the scoreboard
    for (int i = 1; i < 16; i++) begin
      drive(0, 0, 0, 0, 0, 16'h0, 1, 4'(i));
      tick();
    end
    drive(0, 0, 0, 0, 0, 16'h0, 1, 4'd0);
    chk("pc_15", 16'(pc_b), 16'd15);
    tick();
    drive(0, 0, 0, 0, 0, 16'h0, 0, 0);
    chk("pc_15_r0", 16'(pc_b), 16'd15);

    // Reset mid-operation discards the write and the pending entries
    drive(0, 0, 0, 1, 4'd2, 16'h00FF, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 16'h0, 1, 4'd2);
    tick();
    drive(1, 0, 0, 1, 4'd9, 16'h9999, 1, 4'd3);
    tick();
    drive(0, 4'd2, 4'd9, 0, 0, 16'h0, 0, 0);
    chk("rst_r2", d1_b, 16'h0000);
    chk("rst_r9", d2_b, 16'h0000);
    chk("rst_busy2", 16'(b1_b), 16'd0);
    chk("rst_busy9", 16'(b2_b), 16'd0);
    chk("rst_pc_mid", 16'(pc_b), 16'd0);
    drive(0, 0, 0, 1, 4'd2, 16'h2222, 0, 0);
    tick();
    drive(0, 4'd2, 0, 0, 0, 16'h0, 0, 0);
    chk("post_rst_wb", d1_b, 16'h2222);
    chk("post_rst_pc", 16'(pc_b), 16'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 99) == 0),
            4'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
            16'($urandom), 1'($urandom), 4'($urandom));
      tick();
    end
    drive(0, 4'($urandom), 4'($urandom), 0, 0, 16'h0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
